// File: rtl/addr_gen_pipe.sv
// rtl/addr_gen_pipe.sv - pipelined PC/REG/JALR target address generator
// Sum and flags formed at the input, then carried through STAGES bubble-collapsing registers.
module addr_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int STAGES      = 2,
  parameter int ALIGN_BYTES = 4,
  parameter int INST_BYTES  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mode,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] imm_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] addr_out,
  output logic [XLEN-1:0] link_out,
  output logic            misalign,
  output logic            bad_mode
);

  localparam logic [1:0] MODE_PC_REL = 2'b00;
  localparam logic [1:0] MODE_JALR   = 2'b10;
  localparam logic [1:0] MODE_BAD    = 2'b11;
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN_BYTES - 1);
  localparam int LAST = STAGES - 1;

  logic [XLEN-1:0] base, sum, addr_c, link_c;
  logic            mis_c, bad_c;

  always_comb begin
    base   = (mode == MODE_PC_REL) ? pc_in : rs1_in;
    sum    = base + imm_in;
    addr_c = sum;
    bad_c  = 1'b0;
    case (mode)
      MODE_JALR: addr_c = {sum[XLEN-1:1], 1'b0};
      MODE_BAD: begin
        addr_c = '0;
        bad_c  = 1'b1;
      end
      default: ;
    endcase
    mis_c = |(addr_c & ALIGN_MASK);
  end

  assign link_c = pc_in + XLEN'(INST_BYTES);

  logic [STAGES-1:0] v, adv;
  logic [STAGES-1:0] v_d, m_d, b_d, m_q, b_q;
  logic [XLEN-1:0]   a_d [STAGES];
  logic [XLEN-1:0]   l_d [STAGES];
  logic [XLEN-1:0]   a_q [STAGES];
  logic [XLEN-1:0]   l_q [STAGES];

  // A stage may load whenever any stage at or after it holds a bubble, or the output drains.
  always_comb begin
    logic run;
    adv       = '0;
    run       = out_ready | ~v[LAST];
    adv[LAST] = run;
    for (int k = LAST - 1; k >= 0; k--) begin
      run    = run | ~v[k];
      adv[k] = run;
    end
  end

  assign in_ready = adv[0] & ~flush;

  always_comb begin
    v_d    = '0;
    m_d    = '0;
    b_d    = '0;
    v_d[0] = in_valid & in_ready;
    a_d[0] = addr_c;
    l_d[0] = link_c;
    m_d[0] = mis_c;
    b_d[0] = bad_c;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = v[k-1];
      a_d[k] = a_q[k-1];
      l_d[k] = l_q[k-1];
      m_d[k] = m_q[k-1];
      b_d[k] = b_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v   <= '0;
      m_q <= '0;
      b_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        l_q[k] <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v[k]   <= v_d[k];
          a_q[k] <= a_d[k];
          l_q[k] <= l_d[k];
          m_q[k] <= m_d[k];
          b_q[k] <= b_d[k];
        end
      end
    end
  end

  assign out_valid = v[LAST];
  assign addr_out  = a_q[LAST];
  assign link_out  = l_q[LAST];
  assign misalign  = v[LAST] & m_q[LAST];
  assign bad_mode  = v[LAST] & b_q[LAST];

endmodule

// File: tb/tb_addr_gen_pipe.sv
// tb/tb_addr_gen_pipe.sv - directed bench for addr_gen_pipe with expected-result queue
module tb_addr_gen_pipe;
  localparam int XLEN   = 32;
  localparam int STAGES = 2;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]      mode;
  logic [XLEN-1:0] pc_in, rs1_in, imm_in, addr_out, link_out;
  logic            misalign, bad_mode;

  addr_gen_pipe #(.XLEN(XLEN), .STAGES(STAGES), .ALIGN_BYTES(4), .INST_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .pc_in(pc_in), .rs1_in(rs1_in), .imm_in(imm_in),
    .out_valid(out_valid), .out_ready(out_ready), .addr_out(addr_out), .link_out(link_out),
    .misalign(misalign), .bad_mode(bad_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] link;
    logic        mis;
    logic        bad;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds the request until accepted, pushing its expected result at the accepting edge.
  task automatic send(input logic [1:0] m, input logic [31:0] p, input logic [31:0] r,
                      input logic [31:0] i, input logic [31:0] ea, input logic [31:0] el,
                      input logic em, input logic eb);
    int  n    = 0;
    bit  done = 1'b0;
    mode = m; pc_in = p; rs1_in = r; imm_in = i; in_valid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{ea, el, em, eb});
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("addr", addr_out, e.addr);
          chk("link", link_out, e.link);
          chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
          chk("bad_mode", {31'd0, bad_mode}, {31'd0, e.bad});
        end
      end
      if (flush) sb.delete();
    end
  end

  initial begin
    int          lat;
    logic [31:0] snap_a, snap_l, r, p, ii;
    bit          have_snap;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; pc_in = '0; rs1_in = '0; imm_in = '0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", addr_out, 32'd0);
    chk("rst_link", link_out, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_bad_mode", {31'd0, bad_mode}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // T1 with latency measurement
    send(2'b01, 32'h12345678, 32'h98765432, 32'h0000000F, 32'h98765441, 32'h1234567C, 1'b1, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t1_latency", lat, STAGES);
    repeat (3) @(posedge clk); #1;

    // T2 .. T4
    send(2'b00, 32'h12345678, 32'h0, 32'h00000001, 32'h12345679, 32'h1234567C, 1'b1, 1'b0);
    send(2'b00, 32'h12345678, 32'h0, 32'h00000008, 32'h12345680, 32'h1234567C, 1'b0, 1'b0);
    send(2'b10, 32'h00000100, 32'h00001001, 32'h00000002, 32'h00001002, 32'h00000104, 1'b1, 1'b0);
    send(2'b00, 32'hFFFFFFFC, 32'h0, 32'h00000008, 32'h00000004, 32'h00000000, 1'b0, 1'b0);
    send(2'b01, 32'h00000010, 32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000014, 1'b0, 1'b0);
    send(2'b01, 32'h00000020, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000024, 1'b0, 1'b0);
    send(2'b11, 32'h00000200, 32'h00000005, 32'h00000003, 32'h00000000, 32'h00000204, 1'b0, 1'b1);
    repeat (STAGES + 3) @(posedge clk); #1;
    chk("t4_drained", sb.size(), 32'd0);

    // T5: back-pressure with six back-to-back requests
    out_ready = 1'b0;
    have_snap = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          r  = 32'h1000 * (i + 1);
          p  = 32'h40 * i;
          ii = i;
          send(2'b01, p, r, ii, r + ii, p + 32'd4, ii[1:0] != 2'b00, 1'b0);
        end
      end
      begin
        repeat (5) begin
          @(posedge clk); #1;
          if (out_valid) begin
            if (have_snap) begin
              chk("t5_stall_addr", addr_out, snap_a);
              chk("t5_stall_link", link_out, snap_l);
            end else begin
              snap_a    = addr_out;
              snap_l    = link_out;
              have_snap = 1'b1;
            end
          end
        end
        chk("t5_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("t5_accepted", sb.size(), STAGES);
        chk("t5_head_addr", snap_a, 32'h00001000);
        out_ready = 1'b1;
      end
    join
    repeat (STAGES + 4) @(posedge clk); #1;
    chk("t5_drained", sb.size(), 32'd0);

    // T6: flush a full pipe with a concurrent request
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      r = 32'h2000 + 32'h10 * i;
      send(2'b01, 32'h0, r, 32'h0, r, 32'h4, 1'b0, 1'b0);
    end
    flush = 1'b1;
    send_concurrent: begin
      mode = 2'b01; pc_in = 32'h0; rs1_in = 32'h3000; imm_in = 32'h0; in_valid = 1'b1;
    end
    @(negedge clk);
    chk("t6_in_ready_flush", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("t6_out_valid_after", {31'd0, out_valid}, 32'd0);
    chk("t6_addr_kept", addr_out, 32'h00002000);
    out_ready = 1'b1;
    repeat (STAGES + 1) begin
      @(posedge clk); #1;
      chk("t6_no_accept", {31'd0, out_valid}, 32'd0);
    end

    // Async reset pulse mid-stream
    send(2'b00, 32'h00000400, 32'h0, 32'h00000004, 32'h00000404, 32'h00000404, 1'b0, 1'b0);
    send(2'b00, 32'h00000500, 32'h0, 32'h00000004, 32'h00000504, 32'h00000504, 1'b0, 1'b0);
    chk("rst2_pre_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_addr", addr_out, 32'd0);
    chk("rst2_link", link_out, 32'd0);
    chk("rst2_misalign", {31'd0, misalign}, 32'd0);
    chk("rst2_bad_mode", {31'd0, bad_mode}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send(2'b10, 32'h00000600, 32'h00000803, 32'h00000001, 32'h00000804, 32'h00000604, 1'b0, 1'b0);
    repeat (STAGES + 3) @(posedge clk); #1;
    chk("final_drained", sb.size(), 32'd0);
    chk("final_idle", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
